// File: rtl/ack_key_gen.sv
// ack_key_gen: receive-side acknowledgement generator for UDP key tracking.
// Accepts one key at a time and looks it up against a history of recent
// first-seen keys. It then queues {opcode, key} into a show-ahead ack FIFO.
// Opcode 0 marks a first-seen key and opcode 1 marks a duplicate.
//
// Optional feature macro: ACK_DUP_FILTER_EN. When it is defined, the key
// history and duplicate detection are built. When it is undefined, every
// lookup misses, ack_opcode is 0 and dup_count stays 0.
//
// Ports:
//   axis_clk, axis_rstn             clock, async active-low reset
//   rx_key_valid/rx_key/rx_key_ready  key input handshake (64-bit key)
//   ack_key_valid/ack_key/ack_opcode/ack_key_ready  ack output handshake
//   ack_count                       acks handed off (saturating, 32-bit)
//   dup_count                       duplicates detected (saturating, 32-bit)
module ack_key_gen #(
  parameter int unsigned HIST_DEPTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        axis_clk,
  input  logic        axis_rstn,
  input  logic        rx_key_valid,
  input  logic [63:0] rx_key,
  output logic        rx_key_ready,
  output logic        ack_key_valid,
  output logic [63:0] ack_key,
  output logic        ack_opcode,
  input  logic        ack_key_ready,
  output logic [31:0] ack_count,
  output logic [31:0] dup_count
);

  localparam int unsigned KEY_W   = 64;
  localparam int unsigned ENTRY_W = KEY_W + 1;
  localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CNT_W   = 32;

  typedef enum logic [0:0] {IDLE, LOOKUP} state_t;

  state_t               state, next_state;
  logic                 accept_c, push_c, pop_c, hit_c;
  logic [KEY_W-1:0]     key_q;
  logic [ENTRY_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]   fifo_wr, fifo_rd, fifo_rd_n;
  logic [OCC_W-1:0]     occ, occ_n;
  logic [ENTRY_W-1:0]   push_entry, head_q, head_n;
  logic                 ready_n;

  // State register
  always_ff @(posedge axis_clk or negedge axis_rstn) begin
    if (!axis_rstn) state <= IDLE;
    else            state <= next_state;
  end

  // Next-state and handshake strobes
  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    push_c     = 1'b0;
    case (state)
      IDLE: begin
        if (rx_key_valid && rx_key_ready) begin
          accept_c   = 1'b1;
          next_state = LOOKUP;
        end
      end
      LOOKUP: begin
        push_c     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign pop_c      = ack_key_valid && ack_key_ready;
  assign push_entry = {hit_c, key_q};

  // Captured key for the single in-flight lookup
  always_ff @(posedge axis_clk or negedge axis_rstn) begin
    if (!axis_rstn)    key_q <= '0;
    else if (accept_c) key_q <= rx_key;
  end

`ifdef ACK_DUP_FILTER_EN
  localparam int unsigned HIST_AW = $clog2(HIST_DEPTH);

  logic [KEY_W-1:0]      hist_key [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] hist_vld;
  logic [HIST_AW-1:0]    hist_ptr;

  // Parallel compare against every valid history entry
  always_comb begin
    hit_c = 1'b0;
    for (int i = 0; i < int'(HIST_DEPTH); i++) begin
      if (hist_vld[i] && (hist_key[i] == key_q)) hit_c = 1'b1;
    end
  end

  // Round-robin history replacement on first-seen keys
  always_ff @(posedge axis_clk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      hist_vld <= '0;
      hist_ptr <= '0;
    end else if (push_c && !hit_c) begin
      hist_vld[hist_ptr] <= 1'b1;
      hist_ptr           <= hist_ptr + HIST_AW'(1);
    end
  end

  always_ff @(posedge axis_clk) begin
    if (push_c && !hit_c) hist_key[hist_ptr] <= key_q;
  end
`else
  // No history is kept; the comparison is false for every legal depth.
  assign hit_c = (HIST_DEPTH == 0);
`endif

  // FIFO next read pointer and occupancy
  always_comb begin
    fifo_rd_n = pop_c ? fifo_rd + FIFO_AW'(1) : fifo_rd;
    occ_n     = occ;
    if (push_c && !pop_c)      occ_n = occ + OCC_W'(1);
    else if (!push_c && pop_c) occ_n = occ - OCC_W'(1);
  end

  // Registered head: bypass the pushed entry when it lands in the head slot
  always_comb begin
    head_n = '0;
    if (occ_n != '0) begin
      if (push_c && (fifo_wr == fifo_rd_n)) head_n = push_entry;
      else                                  head_n = fifo_mem[fifo_rd_n];
    end
  end

  assign ready_n = (next_state == IDLE) && (occ_n < OCC_W'(FIFO_DEPTH));

  // FIFO storage (data only, no reset needed)
  always_ff @(posedge axis_clk) begin
    if (push_c) fifo_mem[fifo_wr] <= push_entry;
  end

  // FIFO control, registered outputs and counters
  always_ff @(posedge axis_clk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      fifo_wr       <= '0;
      fifo_rd       <= '0;
      occ           <= '0;
      head_q        <= '0;
      ack_key_valid <= 1'b0;
      rx_key_ready  <= 1'b0;
      ack_count     <= '0;
      dup_count     <= '0;
    end else begin
      if (push_c) fifo_wr <= fifo_wr + FIFO_AW'(1);
      fifo_rd       <= fifo_rd_n;
      occ           <= occ_n;
      head_q        <= head_n;
      ack_key_valid <= (occ_n != '0);
      rx_key_ready  <= ready_n;
      if (pop_c && (ack_count != '1))           ack_count <= ack_count + CNT_W'(1);
      if (push_c && hit_c && (dup_count != '1)) dup_count <= dup_count + CNT_W'(1);
    end
  end

  assign ack_key    = head_q[KEY_W-1:0];
  assign ack_opcode = head_q[KEY_W];

endmodule
